// File: rtl/maxnet_controller.sv
// Control FSM for the Maxnet datapath: loads weights/activations, iterates the process units, reports the winner.
// Latency: first strt 18 cycles after start is sampled; each iteration costs strt + PU latency + one write-back cycle.
// Backpressure: none; start is ignored while busy and the FSM simply waits in WAIT until pu_done rises.
module maxnet_controller #(
  parameter int MAX_ITER = 16,
  parameter int ITER_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              dp_done,
  input  logic              pu_done,
  input  logic [2:0]        max_in,
  output logic              we1,
  output logic              we2,
  output logic              we3,
  output logic              we4,
  output logic              We1,
  output logic              We2,
  output logic              We3,
  output logic              We4,
  output logic              sel,
  output logic              mem_we,
  output logic              mem_read,
  output logic              mem_rst,
  output logic              strt,
  output logic [2:0]        mem_addr,
  output logic              busy,
  output logic              result_valid,
  output logic [2:0]        winner,
  output logic              timeout,
  output logic [ITER_W-1:0] iter_count
);

  localparam logic [ITER_W-1:0] MAX_CNT = ITER_W'(MAX_ITER);

  typedef enum logic [3:0] {
    S_IDLE,
    S_INIT,
    S_LDW_RD,
    S_LDW_WR,
    S_LDX_RD,
    S_LDX_WR,
    S_START,
    S_WAIT,
    S_UPDATE,
    S_FINISH
  } state_t;

  state_t            state, state_nxt;
  logic [2:0]        cnt, cnt_nxt;
  logic [ITER_W-1:0] iter_nxt;
  logic [2:0]        winner_nxt;
  logic              timeout_nxt;

  // The datapath memory is never written from here.
  assign mem_we = 1'b0;
  assign busy   = (state != S_IDLE);

  // State, load address counter and run results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      iter_count <= '0;
      winner     <= '0;
      timeout    <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      iter_count <= iter_nxt;
      winner     <= winner_nxt;
      timeout    <= timeout_nxt;
    end
  end

  // Next-state decode and Moore strobes; memory addresses 0-3 hold weights, 4-7 activations.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    iter_nxt     = iter_count;
    winner_nxt   = winner;
    timeout_nxt  = timeout;
    we1          = 1'b0;
    we2          = 1'b0;
    we3          = 1'b0;
    we4          = 1'b0;
    We1          = 1'b0;
    We2          = 1'b0;
    We3          = 1'b0;
    We4          = 1'b0;
    sel          = 1'b0;
    mem_read     = 1'b0;
    mem_rst      = 1'b0;
    strt         = 1'b0;
    mem_addr     = 3'd0;
    result_valid = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt   = S_INIT;
          iter_nxt    = '0;
          winner_nxt  = '0;
          timeout_nxt = 1'b0;
        end
      end
      S_INIT: begin
        mem_rst   = 1'b1;
        cnt_nxt   = 3'd0;
        state_nxt = S_LDW_RD;
      end
      S_LDW_RD: begin
        mem_read  = 1'b1;
        mem_addr  = cnt;
        state_nxt = S_LDW_WR;
      end
      S_LDW_WR: begin
        // Memory data for address cnt is valid now; capture into weight cnt+1.
        mem_read = 1'b1;
        mem_addr = cnt;
        case (cnt[1:0])
          2'd0:    We1 = 1'b1;
          2'd1:    We2 = 1'b1;
          2'd2:    We3 = 1'b1;
          default: We4 = 1'b1;
        endcase
        cnt_nxt   = cnt + 3'd1;
        state_nxt = (cnt == 3'd3) ? S_LDX_RD : S_LDW_RD;
      end
      S_LDX_RD: begin
        mem_read  = 1'b1;
        mem_addr  = cnt;
        sel       = 1'b1;
        state_nxt = S_LDX_WR;
      end
      S_LDX_WR: begin
        // Activation index is cnt-3, i.e. the low two address bits plus one.
        mem_read = 1'b1;
        mem_addr = cnt;
        sel      = 1'b1;
        case (cnt[1:0])
          2'd0:    we1 = 1'b1;
          2'd1:    we2 = 1'b1;
          2'd2:    we3 = 1'b1;
          default: we4 = 1'b1;
        endcase
        if (cnt == 3'd7) begin
          state_nxt = S_START;
        end else begin
          cnt_nxt   = cnt + 3'd1;
          state_nxt = S_LDX_RD;
        end
      end
      S_START: begin
        strt      = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // dp_done only counts alongside pu_done; a joint assertion finishes without write-back.
        if (pu_done) begin
          if (dp_done) begin
            winner_nxt = max_in;
            state_nxt  = S_FINISH;
          end else begin
            state_nxt = S_UPDATE;
          end
        end
      end
      S_UPDATE: begin
        we1      = 1'b1;
        we2      = 1'b1;
        we3      = 1'b1;
        we4      = 1'b1;
        iter_nxt = iter_count + ITER_W'(1);
        if (iter_nxt == MAX_CNT) begin
          timeout_nxt = 1'b1;
          winner_nxt  = '0;
          state_nxt   = S_FINISH;
        end else begin
          state_nxt = S_START;
        end
      end
      S_FINISH: begin
        result_valid = 1'b1;
        state_nxt    = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule
